module_name_dut: RTL and testbench
==================================

# module_name_dut

Nibble pair-summer on the 50 MHz fabric clock. Takes a stream of strobed 4-bit samples, adds each consecutive pair into a 5-bit result, and emits the result with a one-cycle valid pulse. An optional timeout flushes an unpaired sample so a stalled stream never holds data indefinitely. Sits between a slow nibble-wide source and a downstream register/counter stage.

## Interface

Parameters:
- TIMEOUT, 8: idle cycles in the half-pair state before a flush. Legal range 1..255.

Ports:
- clk, input, 1: single clock, rising edge. Nominal period 20 ns.
- rst_n, input, 1: synchronous, active-high reset. Asserted when 1, sampled on the clk rising edge.
- din0, input, 4: sample data, unsigned.
- din1, input, 1: sample strobe. din0 is valid in any cycle where din1 = 1.
- dout0, output, 1: result-valid pulse, one cycle wide.
- dout1, output, 5: pair sum or flushed sample, unsigned.

## Operation

FSM states: S_EMPTY and S_HALF. Held register A is 4 bits.
- S_EMPTY with din1 = 1: A <= din0, go to S_HALF, clear the timeout counter.
- S_EMPTY with din1 = 0: stay in S_EMPTY.
- S_HALF with din1 = 1: dout1 <= A + din0, computed zero-extended to 5 bits, so there is no overflow (max 15 + 15 = 30). dout0 <= 1. Go to S_EMPTY.
- S_HALF with din1 = 0: increment the timeout counter. See Configuration for the flush.
- dout0 is 0 in every cycle that does not produce a result.
- dout1 holds the last result until the next result. It is not cleared when dout0 drops.
- din0 is ignored whenever din1 = 0.
- Back-to-back strobes pair strictly in order: 1st+2nd, 3rd+4th, and so on.

## Timing

- Reset (rst_n = 1 at a rising edge) sets state = S_EMPTY, A = 0, counter = 0, dout0 = 0, dout1 = 0.
- Reset has priority over every other event. Asserting reset while in S_HALF discards the held sample, and no result is emitted.
- Latency: the result is registered. dout0 and dout1 update on the same edge that samples the second strobe and are visible for the following cycle.
- Continuous strobing gives one result every 2 cycles.
- A strobe arriving in the same cycle the timeout expires wins: a normal pair sum is produced and no flush occurs.

## Configuration

- MODULE_NAME_TIMEOUT_EN defined: in S_HALF, after TIMEOUT consecutive cycles with din1 = 0, the block flushes.
  - On the flush edge, dout1 <= {1'b0, A} and dout0 <= 1, and the FSM goes to S_EMPTY.
  - The flush edge is the TIMEOUT-th non-strobe cycle.
- MODULE_NAME_TIMEOUT_EN not defined: there is no counter logic. S_HALF waits indefinitely for a second strobe, and the TIMEOUT parameter is unused.

## Structure

- Shared package module_name_pkg contains:
  - the state enum (S_EMPTY, S_HALF);
  - the constants DIN_W = 4, DOUT_W = 5, CNT_W = 8.
- One sub-module, module_name_tmo:
  - an 8-bit idle counter with clear and enable inputs and an expired output;
  - instantiated only under MODULE_NAME_TIMEOUT_EN.

## Test plan

- Reset: hold rst_n = 1 for 3 cycles with din1 toggling → dout0 = 0 and dout1 = 0 throughout. After release, the first strobe is treated as the first of a pair.
- Basic pair: strobe din0 = 3, then din0 = 5 on consecutive cycles → dout1 = 6'd8 truncated to 5 bits, i.e. 5'd8, with dout0 high for exactly 1 cycle.
- Max value: strobe din0 = 15 twice → dout1 = 30, dout0 = 1.
- Stream of four: strobes 1, 2, 4, 8 back-to-back → two pulses with dout1 = 3, then 12. dout1 holds 12 afterwards.
- Timeout (macro defined, TIMEOUT = 8): strobe din0 = 9, then 8 idle cycles → dout1 = 9 with one dout0 pulse. A strobe on exactly the 8th idle cycle with din0 = 2 → dout1 = 11 instead, and no flush.
- Reset mid-pair: strobe din0 = 7, assert reset, release, strobe 1 then 1 → the only result is dout1 = 2.

Source files
------------

// File: rtl/module_name_pkg.sv
// module_name_pkg: shared state encoding and widths for the nibble pair-summer
package module_name_pkg;
  typedef enum logic {S_EMPTY, S_HALF} state_e;
  localparam int DIN_W = 4;
  localparam int DOUT_W = 5;
  localparam int CNT_W = 8;
endpackage

// File: rtl/module_name_tmo.sv
// module_name_tmo: idle counter that flags the LIMIT-th consecutive enabled cycle
module module_name_tmo
  import module_name_pkg::*;
#(
  parameter int LIMIT = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = clr_i ? '0 : en_i ? cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge clk)
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
  // cnt_q counts idle cycles already seen, so the current idle cycle is the LIMIT-th at LIMIT-1
  assign expired_o = en_i && (cnt_q == CNT_W'(LIMIT - 1));
endmodule

// File: rtl/module_name_dut.sv
// module_name_dut: sums consecutive strobed nibbles; MODULE_NAME_TIMEOUT_EN adds an unpaired-sample flush
module module_name_dut
  import module_name_pkg::*;
#(
  parameter int TIMEOUT = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DIN_W-1:0]  din0,
  input  logic              din1,
  output logic              dout0,
  output logic [DOUT_W-1:0] dout1
);
  state_e state_q, state_d;
  logic [DIN_W-1:0] a_q, a_d;
  logic [DOUT_W-1:0] sum_d;
  logic v_d;
  logic flush;
  wire half = (state_q == S_HALF);
`ifdef MODULE_NAME_TIMEOUT_EN
  logic expired;
  module_name_tmo #(.LIMIT(TIMEOUT)) u_tmo (
    .clk      (clk),
    .rst      (rst_n),
    .clr_i    (!half),
    .en_i     (half && !din1),
    .expired_o(expired)
  );
  assign flush = expired;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT != 0);
  assign flush = 1'b0;
`endif
  always_ff @(posedge clk)
    if (rst_n) begin
      state_q <= S_EMPTY;
      a_q <= '0;
      dout0 <= 1'b0;
      dout1 <= '0;
    end else begin
      state_q <= state_d;
      a_q <= a_d;
      dout0 <= v_d;
      dout1 <= sum_d;
    end
  always_comb state_d = !half ? (din1 ? S_HALF : S_EMPTY) : ((din1 || flush) ? S_EMPTY : S_HALF);
  always_comb begin
    a_d = (!half && din1) ? din0 : a_q;
    v_d = half && (din1 || flush);
    sum_d = !v_d ? dout1 : din1 ? DOUT_W'(a_q) + DOUT_W'(din0) : DOUT_W'(a_q);
  end
endmodule

// File: tb/tb_module_name_dut.sv
// tb_module_name_dut: randomized scoreboard bench against a pairing model of the summer
module tb_module_name_dut;
  localparam int TMO = 8;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic [3:0] din0 = '0;
  logic din1 = 1'b0;
  logic dout0;
  logic [4:0] dout1;
  module_name_dut #(.TIMEOUT(TMO)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .din0 (din0),
    .din1 (din1),
    .dout0(dout0),
    .dout1(dout1)
  );
  always #10 clk = ~clk;
  typedef struct {bit is_rst; logic [4:0] val; int due;} exp_t;
  exp_t q[$];
  int cyc = 0;
  int compared = 0;
  int mismatched = 0;
  logic [4:0] mon_last = '0;
  bit have = 0;
  int held = 0;
  int idle = 0;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input int act, input int req);
    compared++;
    if (act != req) begin
      mismatched++;
      $display("FAIL %s cycle %0d: got %0d, expected %0d", name, cyc, act, req);
    end
  endtask
  task automatic push(input bit r, input int v);
    exp_t e;
    e.is_rst = r;
    e.val = 5'(v);
    e.due = cyc + 1;
    q.push_back(e);
  endtask
  task automatic step(input bit r, input bit s, input logic [3:0] d);
    rst_n = r;
    din1 = s;
    din0 = d;
    if (r) begin
      have = 0;
      idle = 0;
      push(1, 0);
    end else if (!have) begin
      if (s) begin
        have = 1;
        held = d;
        idle = 0;
      end
    end else if (s) begin
      push(0, held + d);
      have = 0;
    end else begin
`ifdef MODULE_NAME_TIMEOUT_EN
      idle++;
      if (idle == TMO) begin
        push(0, held);
        have = 0;
      end
`endif
    end
    @(posedge clk);
    #1;
  endtask
  always @(negedge clk) begin
    if (cyc >= 1) begin
      if (q.size() != 0 && q[0].due == cyc) begin
        exp_t e;
        e = q.pop_front();
        if (e.is_rst) begin
          chk("reset_valid", dout0, 0);
          mon_last = '0;
        end else begin
          chk("result_valid", dout0, 1);
          mon_last = e.val;
        end
      end else begin
        chk("idle_valid", dout0, 0);
      end
      chk("dout1", dout1, mon_last);
    end
  end
  initial begin
    for (int i = 0; i < 3; i++) step(1, i[0], 4'(i + 5));
    step(0, 0, 0);
    step(0, 1, 3);
    step(0, 1, 5);
    step(0, 0, 0);
    step(0, 1, 15);
    step(0, 1, 15);
    step(0, 0, 0);
    step(0, 1, 1);
    step(0, 1, 2);
    step(0, 1, 4);
    step(0, 1, 8);
    for (int i = 0; i < 3; i++) step(0, 0, 4'hf);
    step(0, 1, 9);
    for (int i = 0; i < TMO; i++) step(0, 0, 4'(i));
    for (int i = 0; i < 3; i++) step(0, 0, 0);
    step(0, 1, 9);
    for (int i = 0; i < TMO - 1; i++) step(0, 0, 0);
    step(0, 1, 2);
    for (int i = 0; i < 10; i++) step(0, 0, 0);
    step(0, 1, 7);
    step(1, 0, 0);
    step(0, 0, 0);
    step(0, 1, 1);
    step(0, 1, 1);
    step(0, 0, 0);
    for (int i = 0; i < 4000; i++) begin
      int mode;
      mode = int'($urandom_range(0, 9));
      if ($urandom_range(0, 199) == 0) step(1, 1'($urandom), 4'($urandom));
      else if (mode < 2) for (int k = 0; k < int'($urandom_range(TMO - 2, TMO + 2)); k++) step(0, 0, 4'($urandom));
      else step(0, mode > 4, 4'($urandom));
    end
    for (int i = 0; i < TMO + 4; i++) step(0, 0, 0);
    chk("queue_drained", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
